// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scheduler.
package display_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] AN_OFF    = 4'hF;

   typedef logic [1:0] digit_idx_t;

   // Active-low one-hot anode pattern for a digit index.
   function automatic logic [3:0] an_select(input digit_idx_t idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; combinational grant, pointer remembers last winner.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // ptr_q = 1 means requester 1 (B) was granted last, so requester 0 wins a tie.
   logic ptr_q, ptr_d;

   always_comb begin
      gnt = 2'b00;
      if (reset_n) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt[1]) begin
         ptr_d = 1'b1;
      end else if (gnt[0]) begin
         ptr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/display_scheduler.sv
// Four-digit multiplexed 7-segment scheduler with a two-writer frame buffer,
// PWM brightness and per-digit blinking.
module display_scheduler
   import display_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 50000,
   parameter int unsigned BLINK_TICKS = 250
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_a,
   input  logic [1:0] wdig_a,
   input  logic [7:0] wdata_a,
   output logic       gnt_a,
   input  logic       req_b,
   input  logic [1:0] wdig_b,
   input  logic [7:0] wdata_b,
   output logic       gnt_b,
   input  logic [3:0] blink_en,
   input  logic [1:0] bright,
   output logic [7:0] seg,
   output logic [3:0] an,
   output logic       frame_start
);

   localparam int unsigned CntW   = $clog2(CLK_DIV);
   localparam int unsigned BlinkW = $clog2(BLINK_TICKS + 1);
   localparam int unsigned Quarter = CLK_DIV / 4;

   logic [CntW-1:0]   cnt_q, cnt_d;
   digit_idx_t        idx_q, idx_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic              blink_phase_q, blink_phase_d;
   logic [7:0]        buf_q [4];
   logic [7:0]        buf_d [4];
   logic [7:0]        seg_q, seg_d;
   logic [3:0]        an_q, an_d;
   logic              frame_start_q, frame_start_d;
   logic [1:0]        gnt;
   logic              slot_tick;
   logic              an_on;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     ({req_b, req_a}),
      .gnt     (gnt)
   );

   assign gnt_a = gnt[0];
   assign gnt_b = gnt[1];

   assign slot_tick = (cnt_q == CntW'(CLK_DIV - 1));
   assign an_on     = (32'(cnt_q) < ((32'(bright) + 32'd1) * Quarter));

   always_comb begin
      cnt_d         = slot_tick ? '0 : cnt_q + 1'b1;
      idx_d         = slot_tick ? idx_q + 2'd1 : idx_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      // Count each frame as it completes, so the phase flips exactly on a frame boundary.
      if (slot_tick && idx_q == 2'd3) begin
         if (blink_cnt_q == BlinkW'(BLINK_TICKS - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      buf_d = buf_q;
      if (gnt_a) buf_d[wdig_a] = wdata_a;
      if (gnt_b) buf_d[wdig_b] = wdata_b;
   end

   always_comb begin
      frame_start_d = (cnt_q == '0) && (idx_q == 2'd0);
      an_d          = an_on ? an_select(idx_q) : AN_OFF;
      seg_d         = buf_q[idx_q];
      if (!an_on || (blink_phase_q && blink_en[idx_q])) begin
         seg_d = SEG_BLANK;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         idx_q         <= 2'd0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         seg_q         <= SEG_BLANK;
         an_q          <= AN_OFF;
         frame_start_q <= 1'b0;
         for (int i = 0; i < 4; i++) buf_q[i] <= SEG_BLANK;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         frame_start_q <= frame_start_d;
         for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
      end
   end

   assign seg         = seg_q;
   assign an          = an_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized bench for display_scheduler against a time-indexed reference model.
module tb_display_scheduler;

   localparam int unsigned DIV = 8;
   localparam int unsigned BT  = 2;

   logic       clk;
   logic       reset_n;
   logic       req_a, req_b;
   logic [1:0] wdig_a, wdig_b;
   logic [7:0] wdata_a, wdata_b;
   logic       gnt_a, gnt_b;
   logic [3:0] blink_en;
   logic [1:0] bright;
   logic [7:0] seg;
   logic [3:0] an;
   logic       frame_start;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: cycles since reset release, buffer contents, last winner.
   int         t;
   logic [7:0] mbuf [4];
   bit         m_b_last;
   bit         last_ga, last_gb;

   display_scheduler #(
      .CLK_DIV     (DIV),
      .BLINK_TICKS (BT)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_a       (req_a),
      .wdig_a      (wdig_a),
      .wdata_a     (wdata_a),
      .gnt_a       (gnt_a),
      .req_b       (req_b),
      .wdig_b      (wdig_b),
      .wdata_b     (wdata_b),
      .gnt_b       (gnt_b),
      .blink_en    (blink_en),
      .bright      (bright),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0d time %0t", tag, obs, exp, t, $time);
      end
   endtask

   // Outputs registered at the edge that ends model cycle tc.
   task automatic exp_out(input int tc, output logic [7:0] eseg, output logic [3:0] ean,
                          output logic efs);
      int  cnt, idx, phase;
      bit  on;
      cnt   = tc % DIV;
      idx   = (tc / DIV) % 4;
      phase = ((tc / (4 * DIV)) / BT) % 2;
      on    = cnt < (int'(bright) + 1) * (DIV / 4);
      ean   = on ? ~(4'b0001 << idx) : 4'hF;
      if (!on || (phase == 1 && blink_en[idx])) eseg = 8'hFF;
      else eseg = mbuf[idx];
      efs = (tc % (4 * DIV)) == 0;
   endtask

   // One clock: check grants, advance model across the edge, check registered outputs.
   task automatic step();
      logic       ega, egb, efs;
      logic [7:0] eseg;
      logic [3:0] ean;
      #1;
      ega = req_a && (!req_b || m_b_last);
      egb = req_b && !ega;
      chk("gnt_a", gnt_a, ega);
      chk("gnt_b", gnt_b, egb);
      chk("gnt_exclusive", gnt_a & gnt_b, 0);
      exp_out(t, eseg, ean, efs);
      @(posedge clk);
      if (ega) begin mbuf[wdig_a] = wdata_a; m_b_last = 1'b0; end
      if (egb) begin mbuf[wdig_b] = wdata_b; m_b_last = 1'b1; end
      last_ga = ega;
      last_gb = egb;
      t++;
      @(negedge clk);
      chk("seg", seg, eseg);
      chk("an", an, ean);
      chk("frame_start", frame_start, efs);
   endtask

   task automatic model_reset();
      t        = 0;
      m_b_last = 1'b1;
      last_ga  = 1'b0;
      last_gb  = 1'b0;
      for (int i = 0; i < 4; i++) mbuf[i] = 8'hFF;
   endtask

   // Called just after a falling edge; releases reset 2 ns after a later falling edge.
   task automatic do_reset(input int cycles);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_seg", seg, 8'hFF);
      chk("rst_an", an, 4'hF);
      chk("rst_fs", frame_start, 0);
      chk("rst_gnt", {gnt_a, gnt_b}, 0);
      model_reset();
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      chk("rst_hold_seg", seg, 8'hFF);
      chk("rst_hold_an", an, 4'hF);
      chk("rst_hold_gnt", {gnt_a, gnt_b}, 0);
      #2 reset_n = 1'b1;
   endtask

   task automatic drive_random();
      if (!req_a || last_ga) begin
         req_a   = 1'($urandom_range(0, 1));
         wdig_a  = 2'($urandom);
         wdata_a = 8'($urandom);
      end
      if (!req_b || last_gb) begin
         req_b   = 1'($urandom_range(0, 1));
         wdig_b  = 2'($urandom);
         wdata_b = 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bright = 2'($urandom);
      if ($urandom_range(0, 31) == 0) blink_en = 4'($urandom);
   endtask

   initial begin
      reset_n  = 1'b0;
      req_a    = 1'b0;
      req_b    = 1'b0;
      wdig_a   = 2'd0;
      wdig_b   = 2'd0;
      wdata_a  = 8'h00;
      wdata_b  = 8'h00;
      blink_en = 4'h0;
      bright   = 2'd3;
      model_reset();
      @(negedge clk);
      do_reset(3);

      // Idle scan: blank segments, rotating anodes, 32-cycle frame pulse.
      repeat (40) step();

      // Both requesters held: A then B, alternating while held.
      req_a = 1'b1; wdig_a = 2'd0; wdata_a = 8'hC0;
      req_b = 1'b1; wdig_b = 2'd1; wdata_b = 8'hF9;
      repeat (6) step();
      req_a = 1'b0;
      req_b = 1'b0;
      repeat (40) step();

      // Minimum brightness, then blinking digit 0.
      bright = 2'd0;
      repeat (40) step();
      bright   = 2'd3;
      blink_en = 4'b0001;
      repeat (160) step();

      repeat (500) begin
         drive_random();
         step();
      end

      // Mid-slot reset at digit 2 with both requests pending.
      for (int i = 0; i < 64 && !(((t / DIV) % 4) == 2 && (t % DIV) == 3); i++) begin
         drive_random();
         step();
      end
      req_a = 1'b1;
      req_b = 1'b1;
      do_reset(2);
      req_a    = 1'b0;
      req_b    = 1'b0;
      bright   = 2'd3;
      blink_en = 4'h0;
      repeat (40) step();

      repeat (300) begin
         drive_random();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
